// File: rtl/dsi_pkg.sv
// Shared DSI definitions: line geometry, FSM state type, CRC constants,
// common data-type codes and the 6-bit header ECC function.
package dsi;

    localparam int FRAME_LENGTH = 640;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CRC  = 2'd3
    } state_t;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h8408;

    localparam logic [5:0] DT_NULL   = 6'h09;
    localparam logic [5:0] DT_BLANK  = 6'h19;
    localparam logic [5:0] DT_RGB565 = 6'h0E;
    localparam logic [5:0] DT_RGB666 = 6'h1E;
    localparam logic [5:0] DT_RGB888 = 6'h3E;

    // Hamming parity over D[23:0] = {WC_H, WC_L, DI}; the two top bits stay zero.
    function automatic logic [7:0] ecc6(input logic [23:0] d);
        logic [7:0] p;
        p = 8'h00;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13]
             ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14]
             ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15]
             ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15]
             ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18]
             ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17]
             ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

endpackage

// File: rtl/dsi_crc16.sv
// Byte-wide reflected CRC-16 (poly 0x8408) register; present only when
// DSI_CRC_EN is defined, otherwise the packet footer is constant zero.
`ifdef DSI_CRC_EN
module dsi_crc16
    import dsi::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] step;

    // Eight LSB-first shift steps fold one whole byte in a single cycle.
    always_comb begin
        step = crc_q ^ {8'h00, byte_i};
        for (int i = 0; i < 8; i++) begin
            step = step[0] ? ((step >> 1) ^ CRC_POLY) : (step >> 1);
        end
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = step;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule
`endif

// File: rtl/dsi_long_packet_builder.sv
// Serialises one pixel line into a DSI long packet (header, payload, CRC footer).
// DSI_CRC_EN enables the payload CRC; without it the footer is 0x0000.
module dsi_long_packet_builder
    import dsi::*;
#(
    parameter int FRAME_LENGTH = dsi::FRAME_LENGTH,
    parameter int MAX_WC       = FRAME_LENGTH * 3
) (
    input  logic                       pclk,
    input  logic                       rst,
    input  logic [FRAME_LENGTH*24-1:0] payload,
    input  logic                       line_valid,
    output logic                       line_ready,
    input  logic [15:0]                WC,
    input  logic [1:0]                 vc,
    input  logic [5:0]                 data_type,
    output logic [7:0]                 pkt_byte,
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic                       pkt_sop,
    output logic                       pkt_eop,
    output logic                       wc_err,
    output state_t                     dbg_state
);

    // pkt_valid/pkt_ready: a byte moves only when both are high in the same cycle;
    // byte, sop and eop stay frozen while pkt_ready is low.

    state_t                     state_q, state_d;
    logic [FRAME_LENGTH*24-1:0] payload_q, payload_d;
    logic [15:0]                wc_q, wc_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [7:0]                 di_q, di_d;
    logic [7:0]                 ecc_q, ecc_d;
    logic                       wc_err_q, wc_err_d;

    logic        hs;
    logic        wc_bad;
    logic        accept;
    logic [31:0] byte_idx;
    logic [15:0] crc;

    assign wc_bad     = 32'(WC) > 32'(MAX_WC);
    assign line_ready = (state_q == IDLE);
    assign pkt_valid  = (state_q != IDLE);
    assign hs         = pkt_valid && pkt_ready;
    assign accept     = line_valid && line_ready && !wc_bad;
    assign byte_idx   = 32'(cnt_q) * 32'd8;
    assign wc_err     = wc_err_q;
    assign dbg_state  = state_q;

`ifdef DSI_CRC_EN
    logic crc_en;
    assign crc_en = hs && (state_q == PAY);

    dsi_crc16 u_crc (
        .clk_i  (pclk),
        .rst_i  (rst),
        .init_i (accept),
        .en_i   (crc_en),
        .byte_i (pkt_byte),
        .crc_o  (crc)
    );
`else
    assign crc = 16'h0000;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        wc_d      = wc_q;
        di_d      = di_q;
        ecc_d     = ecc_q;
        wc_err_d  = line_valid && line_ready && wc_bad;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    payload_d = payload;
                    wc_d      = WC;
                    di_d      = {vc, data_type};
                    ecc_d     = ecc6({WC, vc, data_type});
                    cnt_d     = 16'd0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                if (hs) begin
                    if (cnt_q == 16'd3) begin
                        cnt_d   = 16'd0;
                        state_d = (wc_q == 16'd0) ? CRC : PAY;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            PAY: begin
                if (hs) begin
                    if (cnt_q == wc_q - 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = CRC;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            CRC: begin
                if (hs) begin
                    if (cnt_q == 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Output byte is a pure function of registered state, so it holds under backpressure.
    always_comb begin
        pkt_byte = 8'h00;
        pkt_sop  = 1'b0;
        pkt_eop  = 1'b0;
        unique case (state_q)
            HDR: begin
                pkt_sop = (cnt_q == 16'd0);
                unique case (cnt_q[1:0])
                    2'd0:    pkt_byte = di_q;
                    2'd1:    pkt_byte = wc_q[7:0];
                    2'd2:    pkt_byte = wc_q[15:8];
                    default: pkt_byte = ecc_q;
                endcase
            end
            PAY: begin
                pkt_byte = payload_q[byte_idx +: 8];
            end
            CRC: begin
                pkt_eop  = (cnt_q == 16'd1);
                pkt_byte = cnt_q[0] ? crc[15:8] : crc[7:0];
            end
            default: begin
                pkt_byte = 8'h00;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            wc_q     <= 16'd0;
            di_q     <= 8'h00;
            ecc_q    <= 8'h00;
            wc_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wc_q     <= wc_d;
            di_q     <= di_d;
            ecc_q    <= ecc_d;
            wc_err_q <= wc_err_d;
        end
    end

    // Line data is only meaningful after an accept, so it carries no reset.
    always_ff @(posedge pclk) begin
        payload_q <= payload_d;
    end

endmodule

// File: tb/tb_dsi_long_packet_builder.sv
// Scoreboard bench for dsi_long_packet_builder: a byte-level packet model feeds
// an expected queue that a negedge monitor drains on every handshake.
module tb_dsi_long_packet_builder;

    localparam int FL     = 640;
    localparam int MAX_WC = FL * 3;

    // ---------------- clock / reset ----------------
    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    logic [FL*24-1:0] payload;
    logic             line_valid;
    logic             line_ready;
    logic [15:0]      WC;
    logic [1:0]       vc;
    logic [5:0]       data_type;
    logic [7:0]       pkt_byte;
    logic             pkt_valid;
    logic             pkt_ready;
    logic             pkt_sop;
    logic             pkt_eop;
    logic             wc_err;
    dsi::state_t      dbg_state;

    dsi_long_packet_builder #(.FRAME_LENGTH(FL), .MAX_WC(MAX_WC)) dut (
        .pclk       (pclk),
        .rst        (rst),
        .payload    (payload),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .WC         (WC),
        .vc         (vc),
        .data_type  (data_type),
        .pkt_byte   (pkt_byte),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_sop    (pkt_sop),
        .pkt_eop    (pkt_eop),
        .wc_err     (wc_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [9:0]  exp_q[$];          // {sop, eop, byte}
    int          wc_err_exp = 0;
    int          ready_mode = 0;    // 0: always ready, 1: toggle, 2: random
    logic [23:0] pix [FL];
    logic [15:0] crc_tbl [256];
    logic [5:0]  ecc_col [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [5:0] ecc_ref(input logic [23:0] d);
        logic [5:0] e = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) e = e ^ ecc_col[i];
        end
        return e;
    endfunction

    task automatic init_tables();
        logic [15:0] c;
        ecc_col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
        for (int i = 0; i < 256; i++) begin
            c = 16'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            crc_tbl[i] = c;
        end
    endtask

    task automatic model_push(input int wc, input logic [7:0] di);
        logic [15:0] w;
        logic [15:0] c;
        logic [15:0] f;
        logic [7:0]  b;
        w = 16'(wc);
        c = 16'hFFFF;
        exp_q.push_back({2'b10, di});
        exp_q.push_back({2'b00, w[7:0]});
        exp_q.push_back({2'b00, w[15:8]});
        exp_q.push_back({4'b0000, ecc_ref({w, di})});
        for (int k = 0; k < wc; k++) begin
            b = 8'(pix[k / 3] >> (8 * (k % 3)));
            exp_q.push_back({2'b00, b});
            c = (c >> 8) ^ crc_tbl[c[7:0] ^ b];
        end
`ifdef DSI_CRC_EN
        f = c;
`else
        f = 16'h0000;
`endif
        exp_q.push_back({2'b00, f[7:0]});
        exp_q.push_back({2'b01, f[15:8]});
    endtask

    // ---------------- driver tasks (entered just after a posedge) ----------------
    task automatic load_payload();
        for (int j = 0; j < FL; j++) payload[j*24 +: 24] = pix[j];
    endtask

    task automatic randomize_pix();
        for (int j = 0; j < FL; j++) pix[j] = 24'($urandom);
    endtask

    task automatic send_line(input int wc, input logic [1:0] v, input logic [5:0] dt, input bit hold);
        int n = 0;
        while (!line_ready && n < 5000) begin
            @(posedge pclk); #1;
            n++;
        end
        check("line_ready_before_send", line_ready, 1);
        WC        = 16'(wc);
        vc        = v;
        data_type = dt;
        load_payload();
        if (wc <= MAX_WC) model_push(wc, {v, dt});
        else wc_err_exp++;
        line_valid = 1'b1;
        @(posedge pclk); #1;
        if (!hold) line_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge pclk); #1;
            cyc++;
        end while (!(line_ready && exp_q.size() == 0) && cyc < 6000);
        check("packet_done", {31'd0, line_ready && exp_q.size() == 0}, 1);
    endtask

    // ---------------- ready driver ----------------
    initial begin : ready_drv
        pkt_ready = 1'b1;
        forever begin
            @(posedge pclk); #1;
            case (ready_mode)
                0:       pkt_ready = 1'b1;
                1:       pkt_ready = ~pkt_ready;
                default: pkt_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [9:0] prev;
        logic [9:0] got;
        bit         hold;
        prev = '0;
        hold = 1'b0;
        forever begin
            @(negedge pclk);
            got = {pkt_sop, pkt_eop, pkt_byte};
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", pkt_valid, 1);
                    check("hold_stable", got, prev);
                end
                if (wc_err) begin
                    check("wc_err_expected", {31'd0, wc_err_exp > 0}, 1);
                    if (wc_err_exp > 0) wc_err_exp--;
                end
                if (pkt_valid && pkt_ready) begin
                    if (exp_q.size() == 0) check("unexpected_byte", pkt_valid, 0);
                    else check("pkt_byte_sop_eop", got, exp_q.pop_front());
                end
                hold = pkt_valid && !pkt_ready;
                prev = got;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d run %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin : main
        int         cyc;
        int         wc;
        int         n;
        int         mode;
        bit         bad;
        logic [1:0] v;
        logic [5:0] dt;

        init_tables();
        line_valid = 1'b0;
        WC         = 16'd0;
        vc         = 2'd0;
        data_type  = 6'd0;
        for (int j = 0; j < FL; j++) pix[j] = 24'h0;
        load_payload();

        repeat (3) @(posedge pclk);
        #1;
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_line_ready", line_ready, 1);
        check("rst_sop", pkt_sop, 0);
        check("rst_eop", pkt_eop, 0);
        check("rst_wc_err", wc_err, 0);
        check("rst_state", dbg_state, dsi::IDLE);
        rst = 1'b0;
        @(posedge pclk); #1;

        // Empty payload: header then footer only.
        ready_mode = 0;
        send_line(0, 2'd0, 6'h01, 1'b0);
        wait_done(cyc);
        check("wc0_ready_return", cyc, 6);

        // Single zero byte.
        pix[0] = 24'h000000;
        send_line(1, 2'd0, 6'h00, 1'b0);
        wait_done(cyc);
        check("wc1_ready_return", cyc, 7);

        // Two pixels under alternating backpressure.
        pix[0] = 24'h332211;
        pix[1] = 24'h665544;
        ready_mode = 1;
        send_line(6, 2'd1, 6'h3E, 1'b0);
        wait_done(cyc);

        // Oversized word count is rejected.
        ready_mode = 0;
        send_line(MAX_WC + 1, 2'd0, 6'h3E, 1'b0);
        bad = 1'b0;
        repeat (8) begin
            if (!line_ready || pkt_valid) bad = 1'b1;
            @(posedge pclk); #1;
        end
        check("reject_stays_idle", bad, 0);
        check("wc_err_seen", wc_err_exp, 0);

        // Reset in the middle of the payload, then a fresh line.
        randomize_pix();
        send_line(20, 2'd2, 6'h3E, 1'b0);
        repeat (8) @(posedge pclk);
        #1;
        rst = 1'b1;
        @(posedge pclk); #1;
        exp_q.delete();
        check("midrst_pkt_valid", pkt_valid, 0);
        check("midrst_line_ready", line_ready, 1);
        check("midrst_eop", pkt_eop, 0);
        rst = 1'b0;
        @(posedge pclk); #1;
        randomize_pix();
        send_line(12, 2'd3, 6'h3E, 1'b0);
        wait_done(cyc);
        check("after_rst_ready_return", cyc, 18);

        // Back-to-back lines with line_valid held high.
        randomize_pix();
        send_line(10, 2'd1, 6'h3E, 1'b1);
        randomize_pix();
        WC        = 16'd9;
        vc        = 2'd2;
        data_type = 6'h1E;
        load_payload();
        model_push(9, {2'd2, 6'h1E});
        n = 0;
        while (!line_ready && n < 5000) begin
            @(posedge pclk); #1;
            n++;
        end
        check("b2b_gap", n, 16);
        @(posedge pclk); #1;
        line_valid = 1'b0;
        check("b2b_second_accept", line_ready, 0);
        wait_done(cyc);

        // Randomised lines and backpressure.
        for (int t = 0; t < 10; t++) begin
            randomize_pix();
            wc   = $urandom_range(0, 48);
            v    = 2'($urandom_range(0, 3));
            dt   = 6'($urandom_range(0, 63));
            mode = $urandom_range(0, 2);
            ready_mode = mode;
            @(posedge pclk); #1;
            send_line(wc, v, dt, 1'b0);
            wait_done(cyc);
            if (mode == 0) check("rand_ready_return", cyc, wc + 6);
        end

        // Full-width line.
        ready_mode = 0;
        @(posedge pclk); #1;
        randomize_pix();
        send_line(MAX_WC, 2'd0, 6'h3E, 1'b0);
        wait_done(cyc);
        check("max_wc_ready_return", cyc, MAX_WC + 6);

        repeat (5) @(posedge pclk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("wc_err_pending", wc_err_exp, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
